vpu_dispatch: RTL and testbench

- Instruction front end sitting directly upstream of the SIMD/scalar VPU (`vpu_simd`).
- Accepts packed 96-bit VPU instructions on a valid/ready stream and buffers them in a small FIFO.
- Unpacks each into the VPU field bus, pulses `start` once, and holds the fields stable until the VPU's `done`.
- Provides retire counting, flush, and a timeout watchdog.

---
 rtl/vpu_dispatch.sv | 168 ++++++++++++++++
 tb/tb_vpu_dispatch.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_dispatch.sv
// vpu_dispatch: instruction front end for the SIMD/scalar VPU.
// Buffers packed instructions in a small FIFO, unpacks the head entry onto the
// VPU field bus, pulses vpu_start once, and holds the fields until vpu_done.
// Also counts retired instructions and runs a watchdog on the WAIT phase.
module vpu_dispatch #(
  parameter int DEPTH       = 4,
  parameter int INSTR_W     = 96,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  input  logic               clear_err,
  output logic               vpu_start,
  input  logic               vpu_done,
  output logic [2:0]         vpu_type,
  output logic [2:0]         vreg_dst,
  output logic [2:0]         vreg_a,
  output logic [2:0]         vreg_b,
  output logic [2:0]         vpu_opcode,
  output logic               scalar_b,
  output logic [12:0]        addr_a,
  output logic [12:0]        addr_b,
  output logic [12:0]        addr_out,
  output logic [12:0]        addr_const,
  output logic [9:0]         opcode,
  output logic               busy,
  output logic               idle,
  output logic [CNT_W-1:0]   retired,
  output logic               err_timeout
);

  // Bits above the addr_const field carry no meaning, so only the used low
  // part of each instruction is stored.
  localparam int FIELD_W = 78;
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W   = PTR_W + 1;
  localparam int WD_W    = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             state;
  logic [FIELD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level;
  logic [WD_W-1:0]    wd_cnt;
  logic [FIELD_W-1:0] head;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full && !flush;
  assign pop      = (state == S_IDLE) && !empty && !flush;
  assign head     = mem[rd_ptr];
  assign busy     = (state != S_IDLE);
  assign idle     = (state == S_IDLE) && empty;

  // Instruction storage; data only, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_instr[FIELD_W-1:0];
    end
  end

  // FIFO pointers and fill level; flush discards queued entries and any push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

  // Issue FSM: latch head fields, pulse start, wait for done or watchdog expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      vpu_start   <= 1'b0;
      vpu_type    <= '0;
      vreg_dst    <= '0;
      vreg_a      <= '0;
      vreg_b      <= '0;
      vpu_opcode  <= '0;
      scalar_b    <= 1'b0;
      addr_a      <= '0;
      addr_b      <= '0;
      addr_out    <= '0;
      opcode      <= '0;
      addr_const  <= '0;
      wd_cnt      <= '0;
      retired     <= '0;
      err_timeout <= 1'b0;
    end else begin
      vpu_start <= 1'b0;
      // A watchdog expiry later in this block overrides a same-cycle clear.
      if (clear_err) begin
        err_timeout <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (pop) begin
            vpu_type   <= head[2:0];
            vreg_dst   <= head[5:3];
            vreg_a     <= head[8:6];
            vreg_b     <= head[11:9];
            vpu_opcode <= head[14:12];
            scalar_b   <= head[15];
            addr_a     <= head[28:16];
            addr_b     <= head[41:29];
            addr_out   <= head[54:42];
            opcode     <= head[64:55];
            addr_const <= head[77:65];
            vpu_start  <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (vpu_done) begin
            retired <= retired + 1'b1;
            state   <= S_IDLE;
          end else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vpu_dispatch.sv
// Testbench for vpu_dispatch: directed stimulus, a queue-based reference model
// compared against the DUT every cycle, and literal expectations per scenario.
module tb_vpu_dispatch;

  localparam int DEPTH = 4;
  localparam int TMO   = 24;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [95:0]      in_instr = '0;
  logic             flush = 1'b0;
  logic             clear_err = 1'b0;
  logic             vpu_start;
  logic             vpu_done = 1'b0;
  logic [2:0]       vpu_type, vreg_dst, vreg_a, vreg_b, vpu_opcode;
  logic             scalar_b;
  logic [12:0]      addr_a, addr_b, addr_out, addr_const;
  logic [9:0]       opcode;
  logic             busy, idle;
  logic [CNT_W-1:0] retired;
  logic             err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  vpu_dispatch #(.DEPTH(DEPTH), .INSTR_W(96), .TIMEOUT_CYC(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .flush(flush), .clear_err(clear_err), .vpu_start(vpu_start), .vpu_done(vpu_done),
    .vpu_type(vpu_type), .vreg_dst(vreg_dst), .vreg_a(vreg_a), .vreg_b(vreg_b),
    .vpu_opcode(vpu_opcode), .scalar_b(scalar_b), .addr_a(addr_a), .addr_b(addr_b),
    .addr_out(addr_out), .addr_const(addr_const), .opcode(opcode), .busy(busy),
    .idle(idle), .retired(retired), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [95:0] mk(input logic [2:0] ty, input logic [2:0] dst,
                                     input logic [2:0] va, input logic [2:0] vb,
                                     input logic [2:0] vop, input logic sb,
                                     input logic [12:0] aa, input logic [12:0] ab,
                                     input logic [12:0] ao, input logic [9:0] opc,
                                     input logic [12:0] ac);
    logic [95:0] r;
    r          = '0;
    r[2:0]     = ty;
    r[5:3]     = dst;
    r[8:6]     = va;
    r[11:9]    = vb;
    r[14:12]   = vop;
    r[15]      = sb;
    r[28:16]   = aa;
    r[41:29]   = ab;
    r[54:42]   = ao;
    r[64:55]   = opc;
    r[77:65]   = ac;
    r[95:78]   = 18'($urandom);
    return r;
  endfunction

  // Reference model: a queue of pending instructions plus the in-flight one.
  logic [95:0]      m_q[$];
  logic [95:0]      m_last = '0;
  bit               m_inflight = 0;
  bit               m_issue = 0;
  int               m_wcnt = 0;
  logic [CNT_W-1:0] m_ret = '0;
  bit               m_err = 0;
  bit               do_pop, do_push, tmo;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete();
        m_last = '0; m_inflight = 0; m_issue = 0; m_wcnt = 0; m_ret = '0; m_err = 0;
      end else begin
        do_pop  = !m_inflight && (m_q.size() > 0) && !flush;
        do_push = in_valid && (m_q.size() < DEPTH) && !flush;
        tmo     = 0;
        if (m_issue) begin
          m_issue = 0;
          m_wcnt  = 0;
        end else if (m_inflight) begin
          if (vpu_done) begin
            m_ret = m_ret + 1'b1;
            m_inflight = 0;
          end else if (m_wcnt == TMO - 1) begin
            tmo = 1;
            m_inflight = 0;
          end else begin
            m_wcnt++;
          end
        end else if (do_pop) begin
          m_last = m_q.pop_front();
          m_inflight = 1;
          m_issue = 1;
        end
        if (tmo) m_err = 1;
        else if (clear_err) m_err = 0;
        if (flush) m_q.delete();
        if (do_push) m_q.push_back(in_instr);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("m_start",    {31'd0, vpu_start},   {31'd0, m_issue});
    chk("m_busy",     {31'd0, busy},        {31'd0, m_inflight});
    chk("m_idle",     {31'd0, idle},        {31'd0, (!m_inflight && m_q.size() == 0)});
    chk("m_in_ready", {31'd0, in_ready},    {31'd0, (m_q.size() < DEPTH)});
    chk("m_retired",  32'(retired),         32'(m_ret));
    chk("m_err",      {31'd0, err_timeout}, {31'd0, m_err});
    chk("m_vpu_type", 32'(vpu_type),        32'(m_last[2:0]));
    chk("m_vreg_dst", 32'(vreg_dst),        32'(m_last[5:3]));
    chk("m_vreg_a",   32'(vreg_a),          32'(m_last[8:6]));
    chk("m_vreg_b",   32'(vreg_b),          32'(m_last[11:9]));
    chk("m_vpu_op",   32'(vpu_opcode),      32'(m_last[14:12]));
    chk("m_scalar_b", {31'd0, scalar_b},    {31'd0, m_last[15]});
    chk("m_addr_a",   32'(addr_a),          32'(m_last[28:16]));
    chk("m_addr_b",   32'(addr_b),          32'(m_last[41:29]));
    chk("m_addr_out", 32'(addr_out),        32'(m_last[54:42]));
    chk("m_opcode",   32'(opcode),          32'(m_last[64:55]));
    chk("m_addr_c",   32'(addr_const),      32'(m_last[77:65]));
  end

  // Record addr_a of every start pulse for ordering checks.
  logic [12:0] starts[$];
  always @(negedge clk) begin
    if (vpu_start) starts.push_back(addr_a);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_start(input string nm);
    for (int k = 0; k < 60 && !vpu_start; k++) tick();
    chk(nm, {31'd0, vpu_start}, 32'd1);
  endtask

  task automatic wait_wait(input string nm);
    for (int k = 0; k < 60 && !(busy && !vpu_start); k++) tick();
    chk(nm, {31'd0, (busy && !vpu_start)}, 32'd1);
  endtask

  task automatic pulse_done();
    vpu_done = 1'b1;
    tick();
    vpu_done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_start", {31'd0, vpu_start}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_retired", 32'(retired), 32'd0);

    // Single VCOMPUTE: push at t, start at t+2
    in_valid = 1'b1;
    in_instr = mk(3'd3, 3'd3, 3'd1, 3'd2, 3'd0, 1'b0, 13'h11, 13'h22, 13'h33, 10'h5, 13'h44);
    tick();
    in_valid = 1'b0;
    chk("t1_start_t1", {31'd0, vpu_start}, 32'd0);
    tick();
    chk("t1_start_t2", {31'd0, vpu_start}, 32'd1);
    chk("t1_type", 32'(vpu_type), 32'd3);
    chk("t1_va", 32'(vreg_a), 32'd1);
    chk("t1_vb", 32'(vreg_b), 32'd2);
    chk("t1_dst", 32'(vreg_dst), 32'd3);
    chk("t1_vop", 32'(vpu_opcode), 32'd0);
    tick(); tick(); tick();
    pulse_done();
    chk("t1_retired", 32'(retired), 32'd1);
    chk("t1_idle", {31'd0, idle}, 32'd1);

    // Fill and backpressure: 6 pushes, the 6th is refused
    starts.delete();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_instr = mk(3'(i), 3'd0, 3'd0, 3'd0, 3'd1, 1'b1, 13'(16 + 8 * i), 13'd0, 13'd0, 10'(i), 13'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      wait_wait("fill_wait");
      pulse_done();
    end
    for (int k = 0; k < 10; k++) tick();
    chk("fill_nstarts", 32'(starts.size()), 32'd5);
    if (starts.size() == 5) begin
      chk("fill_a0", 32'(starts[0]), 32'h10);
      chk("fill_a1", 32'(starts[1]), 32'h18);
      chk("fill_a2", 32'(starts[2]), 32'h20);
      chk("fill_a3", 32'(starts[3]), 32'h28);
      chk("fill_a4", 32'(starts[4]), 32'h30);
    end
    chk("fill_retired", 32'(retired), 32'd6);

    // Field stability over a 20-cycle WAIT
    starts.delete();
    in_valid = 1'b1;
    in_instr = mk(3'd0, 3'd4, 3'd5, 3'd6, 3'd7, 1'b1, 13'h1AB, 13'h0CD, 13'h0EF, 10'h2A, 13'h123);
    tick();
    in_valid = 1'b0;
    wait_start("stab_start");
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("stab_type", 32'(vpu_type), 32'd0);
      chk("stab_opcode", 32'(opcode), 32'h2A);
      chk("stab_start_low", {31'd0, vpu_start}, 32'd0);
    end
    pulse_done();
    chk("stab_nstarts", 32'(starts.size()), 32'd1);
    chk("stab_retired", 32'(retired), 32'd7);

    // Flush with 3 queued and 1 in flight, plus a same-cycle push
    starts.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_instr = mk(3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 1'b0, 13'(256 + 8 * i), 13'd1, 13'd2, 10'd3, 13'd4);
      tick();
    end
    flush = 1'b1;
    in_instr = mk(3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 1'b0, 13'h1FF, 13'd1, 13'd2, 10'd3, 13'd4);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd1);
    pulse_done();
    for (int k = 0; k < 10; k++) tick();
    chk("flush_nstarts", 32'(starts.size()), 32'd1);
    chk("flush_retired", 32'(retired), 32'd8);
    chk("flush_idle", {31'd0, idle}, 32'd1);

    // Watchdog timeout, then the next entry issues
    starts.delete();
    in_valid = 1'b1;
    in_instr = mk(3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 13'h200, 13'd0, 13'd0, 10'd0, 13'd0);
    tick();
    in_instr = mk(3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 13'h208, 13'd0, 13'd0, 10'd0, 13'd0);
    tick();
    in_valid = 1'b0;
    wait_start("tmo_start_x");
    for (int k = 0; k < TMO; k++) tick();
    chk("tmo_err_before", {31'd0, err_timeout}, 32'd0);
    tick();
    chk("tmo_err_set", {31'd0, err_timeout}, 32'd1);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("tmo_next_start", {31'd0, vpu_start}, 32'd1);
    chk("tmo_next_addr", 32'(addr_a), 32'h208);
    wait_wait("tmo_wait_y");
    pulse_done();
    chk("tmo_retired", 32'(retired), 32'd9);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("tmo_err_clr", {31'd0, err_timeout}, 32'd0);
    pulse_done();
    tick();
    chk("tmo_late_done", 32'(retired), 32'd9);

    // Asynchronous reset in the middle of a WAIT
    in_valid = 1'b1;
    in_instr = mk(3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 1'b1, 13'h0AA, 13'h0BB, 13'h0CC, 10'h1F, 13'h0DD);
    tick();
    in_instr = mk(3'd6, 3'd1, 3'd2, 3'd3, 3'd4, 1'b1, 13'h0AB, 13'h0BB, 13'h0CC, 10'h1F, 13'h0DD);
    tick();
    in_valid = 1'b0;
    wait_start("ar_start");
    tick(); tick();
    chk("ar_busy_pre", {31'd0, busy}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_start", {31'd0, vpu_start}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_retired", 32'(retired), 32'd0);
    chk("ar_err", {31'd0, err_timeout}, 32'd0);
    chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
    chk("ar_idle", {31'd0, idle}, 32'd1);
    chk("ar_type", 32'(vpu_type), 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("ar_no_start", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
